// File: rtl/fft_operand_seq.sv
// In-place radix-2 DIT FFT operand sequencer: walks stages/butterflies and feeds the butterfly unit.
// Optional: FFT_OPSEQ_ZERO_IDLE_EN zeroes the A/B operands whenever out_valid is low.

module fft_opseq_lane #(
  parameter int W     = 8,
  parameter int LOG2N = 2,
  localparam int N    = 1 << LOG2N
) (
  input  logic [N*W-1:0]   in_re,
  input  logic [N*W-1:0]   in_im,
  input  logic [LOG2N-1:0] idx,
  output logic [W-1:0]     re,
  output logic [W-1:0]     im
);
  assign re = in_re[idx*W +: W];
  assign im = in_im[idx*W +: W];
endmodule

module fft_operand_seq #(
  parameter int W     = 8,
  parameter int LOG2N = 2,
  localparam int N    = 1 << LOG2N,
  localparam int TW_W = (LOG2N > 1) ? LOG2N - 1 : 1,
  localparam int BW   = (LOG2N > 1) ? LOG2N - 1 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N*W-1:0]   in_re,
  input  logic [N*W-1:0]   in_im,
  input  logic             out_ready,
  input  logic             stage_ack,
  output logic             out_valid,
  output logic [W-1:0]     a_re,
  output logic [W-1:0]     a_im,
  output logic [W-1:0]     b_re,
  output logic [W-1:0]     b_im,
  output logic [LOG2N-1:0] idx_a,
  output logic [LOG2N-1:0] idx_b,
  output logic [TW_W-1:0]  tw_idx,
  output logic [2:0]       stage_idx,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

  localparam logic [BW-1:0] B_LAST = BW'(N/2 - 1);
  localparam logic [2:0]    S_LAST = 3'(LOG2N - 1);

  state_t           state, state_nxt;
  logic [2:0]       s, ld_s;
  logic [BW-1:0]    b, ld_b;
  logic             load, done_nxt;

  logic [LOG2N-1:0]            bx, mask;
  logic [1:0][LOG2N-1:0]       ld_idx;
  logic [1:0][W-1:0]           sel_re, sel_im;
  logic [TW_W-1:0]             ld_tw;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done_nxt  = 1'b0;
    ld_s      = s;
    ld_b      = b;
    case (state)
      IDLE: if (start) begin
        load      = 1'b1;
        ld_s      = 3'd0;
        ld_b      = '0;
        state_nxt = ISSUE;
      end
      ISSUE: if (out_ready) begin
        if (b != B_LAST) begin
          load = 1'b1;
          ld_b = b + 1'b1;
        end else if (s != S_LAST) begin
          state_nxt = WAIT_ACK;
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      WAIT_ACK: if (stage_ack) begin
        load      = 1'b1;
        ld_s      = s + 3'd1;
        ld_b      = '0;
        state_nxt = ISSUE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // g*2h + j is b with the bits at and above s shifted up by one; B simply sets bit s.
  assign bx        = LOG2N'(ld_b);
  assign mask      = (LOG2N'(1) << ld_s) - LOG2N'(1);
  assign ld_idx[0] = ((bx & ~mask) << 1) | (bx & mask);
  assign ld_idx[1] = ld_idx[0] | (LOG2N'(1) << ld_s);
  assign ld_tw     = TW_W'(bx & mask) << (S_LAST - ld_s);

  for (genvar l = 0; l < 2; l++) begin : g_lane
    fft_opseq_lane #(.W(W), .LOG2N(LOG2N)) u_lane (
      .in_re (in_re),
      .in_im (in_im),
      .idx   (ld_idx[l]),
      .re    (sel_re[l]),
      .im    (sel_im[l])
    );
  end

`ifdef FFT_OPSEQ_ZERO_IDLE_EN
  logic clr;
  assign clr = (state == ISSUE) && out_ready && (b == B_LAST);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s      <= '0;
      b      <= '0;
      a_re   <= '0;
      a_im   <= '0;
      b_re   <= '0;
      b_im   <= '0;
      idx_a  <= '0;
      idx_b  <= '0;
      tw_idx <= '0;
      done   <= 1'b0;
    end else begin
      done <= done_nxt;
      if (load) begin
        s      <= ld_s;
        b      <= ld_b;
        a_re   <= sel_re[0];
        a_im   <= sel_im[0];
        b_re   <= sel_re[1];
        b_im   <= sel_im[1];
        idx_a  <= ld_idx[0];
        idx_b  <= ld_idx[1];
        tw_idx <= ld_tw;
      end
`ifdef FFT_OPSEQ_ZERO_IDLE_EN
      else if (clr) begin
        a_re <= '0;
        a_im <= '0;
        b_re <= '0;
        b_im <= '0;
      end
`endif
    end
  end

  assign stage_idx = s;
  assign out_valid = (state == ISSUE);
  assign busy      = (state != IDLE);
endmodule

// File: tb/tb_fft_operand_seq.sv
// Scoreboard bench for fft_operand_seq: 4-point and 8-point instances, directed vectors.
module tb_fft_operand_seq;
  logic clk = 1'b0, rst = 1'b1, start2 = 1'b0, start3 = 1'b0, rdy = 1'b0, ack = 1'b0;
  logic [31:0] re2 = '0, im2 = '0;
  logic [63:0] re3 = '0, im3 = '0;

  logic       v2, busy2, done2, v3, busy3, done3;
  logic [7:0] ar2, ai2, br2, bi2, ar3, ai3, br3, bi3;
  logic [1:0] ia2, ib2;
  logic [0:0] tw2;
  logic [2:0] ia3, ib3, st2, st3;
  logic [1:0] tw3;

  typedef struct packed {
    logic [2:0] ia, ib;
    logic [1:0] tw;
    logic [2:0] st;
    logic [7:0] ar, ai, br, bi;
  } xfer_t;

  xfer_t q2[$], q3[$];
  xfer_t e2, e3;
  int checks = 0, fails = 0;

`ifdef FFT_OPSEQ_ZERO_IDLE_EN
  localparam logic [7:0] WAIT_A_RE = 8'd0;
`else
  localparam logic [7:0] WAIT_A_RE = 8'd30;
`endif

  always #5 clk = ~clk;

  fft_operand_seq #(.W(8), .LOG2N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_re(re2), .in_im(im2),
    .out_ready(rdy), .stage_ack(ack), .out_valid(v2),
    .a_re(ar2), .a_im(ai2), .b_re(br2), .b_im(bi2),
    .idx_a(ia2), .idx_b(ib2), .tw_idx(tw2), .stage_idx(st2),
    .busy(busy2), .done(done2));

  fft_operand_seq #(.W(8), .LOG2N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .in_re(re3), .in_im(im3),
    .out_ready(rdy), .stage_ack(ack), .out_valid(v3),
    .a_re(ar3), .a_im(ai3), .b_re(br3), .b_im(bi3),
    .idx_a(ia3), .idx_b(ib3), .tw_idx(tw3), .stage_idx(st3),
    .busy(busy3), .done(done3));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic xfer_t mk(input int ia, input int ib, input int tw, input int st,
                               input logic [63:0] re, input logic [63:0] im);
    xfer_t x;
    x.ia = 3'(ia); x.ib = 3'(ib); x.tw = 2'(tw); x.st = 3'(st);
    x.ar = re[ia*8 +: 8]; x.ai = im[ia*8 +: 8];
    x.br = re[ib*8 +: 8]; x.bi = im[ib*8 +: 8];
    return x;
  endfunction

  task automatic push2(input int ia, input int ib, input int tw, input int st);
    q2.push_back(mk(ia, ib, tw, st, 64'(re2), 64'(im2)));
  endtask

  task automatic wait_done(input bit big, input int exp, input string name);
    int n;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (big ? done3 : done2) break;
    end
    check(name, 64'(n), 64'(exp));
  endtask

  // Monitors: every accepted transfer is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst && v2 && rdy) begin
      if (q2.size() == 0) check("d2 unexpected transfer", 64'd1, 64'd0);
      else begin
        e2 = q2.pop_front();
        check("d2 transfer", 64'({3'(ia2), 3'(ib2), 2'(tw2), st2, ar2, ai2, br2, bi2}), 64'(e2));
      end
    end
    if (!rst && v3 && rdy) begin
      if (q3.size() == 0) check("d3 unexpected transfer", 64'd1, 64'd0);
      else begin
        e3 = q3.pop_front();
        check("d3 transfer", 64'({ia3, ib3, tw3, st3, ar3, ai3, br3, bi3}), 64'(e3));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pa[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int pb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int pt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    // Reset state
    @(posedge clk); #1;
    check("reset outputs", 64'({v2, busy2, done2, ar2, ai2, br2, bi2, ia2, ib2, tw2, st2}), 64'd0);
    check("reset d3 valid/busy", 64'({v3, busy3, done3}), 64'd0);
    rst = 1'b0;

    // Basic 4-point flow
    re2 = {8'd40, 8'd30, 8'd20, 8'd10};
    im2 = {8'd4, 8'd3, 8'd2, 8'd1};
    rdy = 1'b1; ack = 1'b1;
    push2(0, 1, 0, 0); push2(2, 3, 0, 0); push2(0, 2, 0, 1); push2(1, 3, 1, 1);
    start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    check("start latency valid/busy", 64'({v2, busy2}), 64'b11);
    repeat (2) @(posedge clk); #1;
    check("wait valid/busy", 64'({v2, busy2}), 64'b01);
    check("wait a_re", 64'(ar2), 64'(WAIT_A_RE));
    repeat (3) @(posedge clk); #1;
    check("done cycle", 64'({done2, busy2, v2}), 64'b100);
    @(posedge clk); #1;
    check("done one cycle", 64'(done2), 64'd0);
    check("basic queue drained", 64'(q2.size()), 64'd0);

    // Backpressure on the second butterfly
    push2(0, 1, 0, 0); push2(2, 3, 0, 0); push2(0, 2, 0, 1); push2(1, 3, 1, 1);
    start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    @(posedge clk); #1; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("backpressure hold", 64'({v2, ia2, ib2, ar2, br2}), 64'({1'b1, 2'd2, 2'd3, 8'd30, 8'd40}));
    end
    rdy = 1'b1;
    wait_done(1'b0, 4, "backpressure done latency");
    check("backpressure queue drained", 64'(q2.size()), 64'd0);

    // Stage barrier with in-place update during WAIT_ACK
    ack = 1'b0;
    push2(0, 1, 0, 0); push2(2, 3, 0, 0);
    start2 = 1'b1;
    @(posedge clk); #1; start2 = 1'b0;
    repeat (2) @(posedge clk); #1;
    re2[23:16] = 8'd99;
    push2(0, 2, 0, 1); push2(1, 3, 1, 1);
    for (int k = 0; k < 5; k++) begin
      check("barrier valid low", 64'(v2), 64'd0);
      if (k == 4) ack = 1'b1;
      @(posedge clk); #1;
    end
    check("barrier stage1 operands", 64'({v2, ar2, br2}), 64'({1'b1, 8'd10, 8'd99}));
    wait_done(1'b0, 2, "barrier done latency");
    re2[23:16] = 8'd30;

    // Spurious start/stage_ack while busy, then reset mid stage 1
    rdy = 1'b0; ack = 1'b0;
    push2(0, 1, 0, 0); push2(2, 3, 0, 0);
    start2 = 1'b1;
    @(posedge clk); #1; ack = 1'b1;
    @(posedge clk); #1;
    check("spurious ignored", 64'({v2, st2, ia2}), 64'({1'b1, 3'd0, 2'd0}));
    start2 = 1'b0; ack = 1'b0; rdy = 1'b1;
    repeat (2) @(posedge clk); #1;
    ack = 1'b1; rdy = 1'b0;
    @(posedge clk); #1;
    check("entered stage 1", 64'({v2, st2}), 64'({1'b1, 3'd1}));
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid reset outputs", 64'({v2, busy2, done2, ar2, ai2, br2, bi2, ia2, ib2, tw2, st2}), 64'd0);
    rst = 1'b0; ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no done after abort", 64'({done2, v2, busy2}), 64'd0);
    end
    check("abort queue drained", 64'(q2.size()), 64'd0);

    // 8-point transform
    for (int i = 0; i < 8; i++) begin
      re3[i*8 +: 8] = 8'(10 * (i + 1));
      im3[i*8 +: 8] = 8'(i + 1);
    end
    for (int i = 0; i < 12; i++) q3.push_back(mk(pa[i], pb[i], pt[i], i / 4, re3, im3));
    rdy = 1'b1; ack = 1'b1;
    start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    wait_done(1'b1, 14, "8-point done latency");
    check("8-point queue drained", 64'(q3.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
